// File: rtl/id_ex_pipeline_reg_pkg.sv
// Core-wide decode/execute definitions: datapath widths, control-word bit
// positions and the bubble encoding shared by the ID/EX pipeline register.
package id_ex_pipeline_reg_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  localparam int CTRL_REG_WR_EN = 0;
  localparam int CTRL_MEM_RD    = 1;
  localparam int CTRL_MEM_WR    = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JUMP      = 4;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1Addr;
    logic [4:0]        rs2Addr;
    logic [4:0]        rdAddr;
    logic [CTRL_W-1:0] ctrl;
  } ex_bundle_t;

  localparam ex_bundle_t BUBBLE_BUNDLE = '{
    valid:   1'b0,
    pc:      '0,
    op1:     '0,
    op2:     '0,
    imm:     '0,
    rs1Addr: '0,
    rs2Addr: '0,
    rdAddr:  '0,
    ctrl:    BUBBLE_CTRL
  };

  // x0 is hardwired to zero, so a writeback to it must never look like a hit.
  function automatic logic wbHits(input logic wrEn, input logic [4:0] wrAddr,
                                  input logic [4:0] rsAddr);
    return wrEn && (wrAddr != 5'd0) && (wrAddr == rsAddr);
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Decode-to-execute bus: the decode bundle, writeback snoop and the
// registered execute-stage view, with master (decode side) and slave (register) modports.
interface id_ex_pipeline_reg_if;
  import id_ex_pipeline_reg_pkg::*;

  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_op1;
  logic [XLEN-1:0]   id_op2;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1_addr;
  logic [4:0]        id_rs2_addr;
  logic [4:0]        id_rd_addr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_wr_en;
  logic [4:0]        wb_wr_addr;
  logic [XLEN-1:0]   wb_wr_data;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1_addr;
  logic [4:0]        ex_rs2_addr;
  logic [4:0]        ex_rd_addr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       stall_cnt;

  modport master (
    output stall, flush, id_valid, id_pc, id_op1, id_op2, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_ctrl,
           wb_wr_en, wb_wr_addr, wb_wr_data,
    input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl, stall_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_op1, id_op2, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_ctrl,
           wb_wr_en, wb_wr_addr, wb_wr_data,
    output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl, stall_cnt
  );

endinterface

// File: rtl/id_ex_pipeline_reg_op_refresh.sv
// Next value for one held operand: picks up a matching writeback so a
// stalled instruction does not execute with a stale register value.
module op_refresh
  import id_ex_pipeline_reg_pkg::*;
(
  input  logic [XLEN-1:0] i_heldVal,
  input  logic [4:0]      i_heldAddr,
  input  logic            i_valid,
  input  logic            i_wbWrEn,
  input  logic [4:0]      i_wbWrAddr,
  input  logic [XLEN-1:0] i_wbWrData,
  output logic [XLEN-1:0] o_nextVal
);

  logic w_hit;

  assign w_hit     = i_valid && wbHits(i_wbWrEn, i_wbWrAddr, i_heldAddr);
  assign o_nextVal = w_hit ? i_wbWrData : i_heldVal;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall hold, flush bubble, writeback refresh
// of held operands, and a saturating stall-cycle counter.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  id_ex_pipeline_reg_if.slave bus
);

  ex_bundle_t      r_ex;
  logic [31:0]     r_stallCnt;
  ex_bundle_t      w_idBundle;
  logic [XLEN-1:0] w_op1Next;
  logic [XLEN-1:0] w_op2Next;

  assign w_idBundle = '{
    valid:   1'b1,
    pc:      bus.id_pc,
    op1:     bus.id_op1,
    op2:     bus.id_op2,
    imm:     bus.id_imm,
    rs1Addr: bus.id_rs1_addr,
    rs2Addr: bus.id_rs2_addr,
    rdAddr:  bus.id_rd_addr,
    ctrl:    bus.id_ctrl
  };

  op_refresh u_refreshOp1 (
    .i_heldVal  (r_ex.op1),
    .i_heldAddr (r_ex.rs1Addr),
    .i_valid    (r_ex.valid),
    .i_wbWrEn   (bus.wb_wr_en),
    .i_wbWrAddr (bus.wb_wr_addr),
    .i_wbWrData (bus.wb_wr_data),
    .o_nextVal  (w_op1Next)
  );

  op_refresh u_refreshOp2 (
    .i_heldVal  (r_ex.op2),
    .i_heldAddr (r_ex.rs2Addr),
    .i_valid    (r_ex.valid),
    .i_wbWrEn   (bus.wb_wr_en),
    .i_wbWrAddr (bus.wb_wr_addr),
    .i_wbWrData (bus.wb_wr_data),
    .o_nextVal  (w_op2Next)
  );

  // Priority rst > flush > stall > load; a load with id_valid low is a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex       <= BUBBLE_BUNDLE;
      r_stallCnt <= '0;
    end else if (bus.flush) begin
      r_ex <= BUBBLE_BUNDLE;
    end else if (bus.stall) begin
      r_ex.op1 <= w_op1Next;
      r_ex.op2 <= w_op2Next;
      if (r_ex.valid && (r_stallCnt != 32'hFFFF_FFFF)) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end else if (!bus.id_valid) begin
      r_ex <= BUBBLE_BUNDLE;
    end else begin
      r_ex <= w_idBundle;
    end
  end

  assign bus.ex_valid    = r_ex.valid;
  assign bus.ex_pc       = r_ex.pc;
  assign bus.ex_op1      = r_ex.op1;
  assign bus.ex_op2      = r_ex.op2;
  assign bus.ex_imm      = r_ex.imm;
  assign bus.ex_rs1_addr = r_ex.rs1Addr;
  assign bus.ex_rs2_addr = r_ex.rs2Addr;
  assign bus.ex_rd_addr  = r_ex.rdAddr;
  assign bus.ex_ctrl     = r_ex.ctrl;
  assign bus.stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for the ID/EX pipeline register: load, stall refresh,
// flush priority, bubble loads, stall counter saturation and reset mid-stall.
module tb_id_ex_pipeline_reg;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_ex_pipeline_reg_if bus ();

  id_ex_pipeline_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's decode inputs, then let exactly one rising edge pass.
  task automatic applyStimulus(input logic s, input logic f, input logic v,
                               input logic [31:0] pc, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [15:0] ctrl);
    bus.stall       = s;
    bus.flush       = f;
    bus.id_valid    = v;
    bus.id_pc       = pc;
    bus.id_op1      = op1;
    bus.id_op2      = op2;
    bus.id_imm      = imm;
    bus.id_rs1_addr = rs1;
    bus.id_rs2_addr = rs2;
    bus.id_rd_addr  = rd;
    bus.id_ctrl     = ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic setWb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_wr_en   = en;
    bus.wb_wr_addr = addr;
    bus.wb_wr_data = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    setWb(1'b0, 5'd0, 32'h0);

    // Reset for two edges
    applyStimulus(0, 0, 1, 32'hAAAA, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 16'hFFFF);
    applyStimulus(0, 0, 1, 32'hAAAA, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 16'hFFFF);
    checkOutput("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rst_pc", bus.ex_pc, 32'd0);
    checkOutput("rst_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
    checkOutput("rst_cnt", bus.stall_cnt, 32'd0);
    rst = 1'b0;

    // Plain load
    applyStimulus(0, 0, 1, 32'h100, 32'd5, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0001);
    checkOutput("load_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("load_pc", bus.ex_pc, 32'h100);
    checkOutput("load_op1", bus.ex_op1, 32'd5);
    checkOutput("load_ctrl", {16'd0, bus.ex_ctrl}, 32'h0001);
    checkOutput("load_cnt", bus.stall_cnt, 32'd0);

    // Load with a matching writeback in flight: the id operand wins
    setWb(1'b1, 5'd3, 32'h99);
    applyStimulus(0, 0, 1, 32'h200, 32'd7, 32'd7, 32'h10, 5'd3, 5'd3, 5'd9, 16'h0003);
    checkOutput("load_noref_op1", bus.ex_op1, 32'd7);
    checkOutput("load_noref_op2", bus.ex_op2, 32'd7);
    checkOutput("load_rd", {27'd0, bus.ex_rd_addr}, 32'd9);

    // Stall with refresh of both operands from x3
    setWb(1'b1, 5'd3, 32'h55);
    applyStimulus(1, 0, 1, 32'h300, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("ref_op1", bus.ex_op1, 32'h55);
    checkOutput("ref_op2", bus.ex_op2, 32'h55);
    checkOutput("ref_pc_hold", bus.ex_pc, 32'h200);
    checkOutput("ref_imm_hold", bus.ex_imm, 32'h10);
    checkOutput("ref_cnt", bus.stall_cnt, 32'd1);

    // Writeback to an unrelated register
    setWb(1'b1, 5'd4, 32'h66);
    applyStimulus(1, 0, 1, 32'h300, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("x4_op1", bus.ex_op1, 32'h55);
    checkOutput("x4_op2", bus.ex_op2, 32'h55);

    // Matching address but write enable low
    setWb(1'b0, 5'd3, 32'h77);
    applyStimulus(1, 0, 1, 32'h300, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("noen_op1", bus.ex_op1, 32'h55);
    checkOutput("noen_cnt", bus.stall_cnt, 32'd3);

    // x0 never refreshes, even with rs1=0
    setWb(1'b0, 5'd0, 32'h0);
    applyStimulus(0, 0, 1, 32'h400, 32'd0, 32'h11, 32'd0, 5'd0, 5'd3, 5'd2, 16'h0005);
    setWb(1'b1, 5'd0, 32'hDEAD);
    applyStimulus(1, 0, 1, 32'h500, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("x0_op1", bus.ex_op1, 32'd0);
    checkOutput("x0_op2", bus.ex_op2, 32'h11);
    checkOutput("x0_cnt", bus.stall_cnt, 32'd4);
    setWb(1'b0, 5'd0, 32'h0);

    // Flush beats a simultaneous stall
    applyStimulus(1, 1, 1, 32'h500, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("flush_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
    checkOutput("flush_rd", {27'd0, bus.ex_rd_addr}, 32'd0);
    checkOutput("flush_op2", bus.ex_op2, 32'd0);
    checkOutput("flush_cnt", bus.stall_cnt, 32'd4);

    // Stall on a bubble does not count
    applyStimulus(1, 0, 1, 32'h500, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 16'h00F0);
    checkOutput("bubstall_cnt", bus.stall_cnt, 32'd4);
    checkOutput("bubstall_valid", {31'd0, bus.ex_valid}, 32'd0);

    // id_valid=0 with live-looking data loads a bubble
    applyStimulus(0, 0, 1, 32'h600, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd6, 16'h0001);
    applyStimulus(0, 0, 0, 32'h700, 32'h8, 32'h9, 32'hA, 5'd7, 5'd8, 5'd9, 16'h00FF);
    checkOutput("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("inv_pc", bus.ex_pc, 32'd0);
    checkOutput("inv_op1", bus.ex_op1, 32'd0);
    checkOutput("inv_imm", bus.ex_imm, 32'd0);
    checkOutput("inv_rs1", {27'd0, bus.ex_rs1_addr}, 32'd0);
    checkOutput("inv_rd", {27'd0, bus.ex_rd_addr}, 32'd0);
    checkOutput("inv_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);

    // Stall counter from a clean reset: 10 stalled cycles
    rst = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 1, 32'h800, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    end
    checkOutput("cnt_ten", bus.stall_cnt, 32'd10);
    checkOutput("cnt_pc_hold", bus.ex_pc, 32'h800);

    // Preload near the top and confirm saturation
    force dut.r_stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stallCnt;
    applyStimulus(1, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    checkOutput("cnt_max", bus.stall_cnt, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    applyStimulus(1, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    checkOutput("cnt_sat", bus.stall_cnt, 32'hFFFF_FFFF);

    // Reset while stalled on a valid bundle
    rst = 1'b1;
    applyStimulus(1, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    rst = 1'b0;
    checkOutput("rststall_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rststall_pc", bus.ex_pc, 32'd0);
    checkOutput("rststall_op1", bus.ex_op1, 32'd0);
    checkOutput("rststall_cnt", bus.stall_cnt, 32'd0);
    applyStimulus(1, 0, 1, 32'hA00, 32'h4, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 16'h0001);
    checkOutput("post_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
    applyStimulus(0, 0, 1, 32'hA00, 32'h4, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 16'h0001);
    checkOutput("post_load_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("post_load_pc", bus.ex_pc, 32'hA00);
    checkOutput("post_load_op1", bus.ex_op1, 32'h4);
    checkOutput("post_load_cnt", bus.stall_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
